mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 15, max cycles a granted access waits for ram_ready before timeout (legal 1..255).
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetched word; if_ack out 1 fetch done.
REQ-005 SHALL have ports: mem_read_control in 1 data load; mem_write_control in 1 data store; mem_addr in 32; mem_wdata in 32; mem_rdata out 32 load data; mem_ack out 1 data done.
REQ-006 SHALL have ports: ram_en out 1; ram_we out 1; ram_addr out 32; ram_wdata out 32; ram_rdata in 32; ram_ready in 1; single-port unified memory side.
REQ-007 SHALL have ports: stall out 1 pipeline hold; err out 1 sticky timeout flag.

Function
REQ-008 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RESP.
REQ-009 IDLE: data pending (mem_read_control|mem_write_control) -> GRANT_D; else if_req -> GRANT_I; else stay.
REQ-010 On leaving IDLE, SHALL register address, write data and we (1 iff mem_write_control, GRANT_D only); ram_addr/ram_wdata/ram_we stable for whole grant.
REQ-011 ram_en SHALL be 1 exactly in GRANT_I/GRANT_D, 0 in IDLE/RESP.
REQ-012 In GRANT state with ram_ready=1: capture ram_rdata into if_rdata (GRANT_I) or mem_rdata (GRANT_D, loads only; stores leave mem_rdata unchanged); next state RESP.
REQ-013 RESP: exactly one cycle; if_ack or mem_ack =1 for the served requester only; no new grant; next state IDLE.
REQ-014 Minimum latency: request seen in IDLE at cycle N, ram_ready at N+1, ack at N+2; back-to-back throughput one access per 3 cycles.
REQ-015 Requesters SHALL hold req/address/data until ack; arbiter SHALL not sample them outside IDLE.
REQ-016 Both mem_read_control and mem_write_control =1: SHALL perform store.
REQ-017 Wait counter (8 bits) SHALL clear on grant entry, increment each GRANT cycle with ram_ready=0; when count reaches MAX_WAIT without ready: go RESP, ack served requester, load 32'h0 into its rdata, set err=1.
REQ-018 err SHALL stay 1 until reset; further accesses proceed normally.
REQ-019 stall SHALL be combinational: 1 when (if_req & ~if_ack) | ((mem_read_control|mem_write_control) & ~mem_ack), else 0.
REQ-020 ram_ready=1 while not in GRANT state SHALL be ignored.

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, abandon any in-flight access, and clear if_rdata, mem_rdata, if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata, wait counter, err and priority flag to 0.
REQ-022 Reset mid-grant SHALL produce no ack for the abandoned access; requester re-arbitrates after rst=1.

Configuration
REQ-023 Macro MEM_ARB_RR_EN defined: 1-bit last-grant flag (reset = fetch); when both pending in IDLE, grant the side not last granted; flag updates on every grant.
REQ-024 MEM_ARB_RR_EN undefined: fixed data priority per REQ-009, no flag logic.

Verification
REQ-025 Load: mem_read_control=1, mem_addr=0x100, ram_ready 1 cycle after grant, ram_rdata=0xDEADBEEF -> ram_en one cycle, mem_ack at N+2, mem_rdata=0xDEADBEEF, stall 1 for N..N+1.
REQ-026 Store: mem_write_control=1, mem_addr=0x40, mem_wdata=0x12345678, ready after 3 wait cycles -> ram_we=1, ram_wdata=0x12345678 held 4 cycles, mem_ack once, mem_rdata unchanged.
REQ-027 Contention: if_req and mem_read_control both held 3 accesses -> default build: data, data, data then fetch after data drops; MEM_ARB_RR_EN: data, fetch, data.
REQ-028 Timeout: MAX_WAIT=4, ram_ready never asserted -> ram_en 4 cycles, if_ack once, if_rdata=0, err=1 held until rst=0.
REQ-029 Reset mid-grant: rst=0 in 2nd GRANT_D cycle -> next cycle IDLE, ram_en=0, no mem_ack, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, unified RAM port, status.
// slave = arbiter side, master = requester/RAM side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        mem_read_control;
    logic        mem_write_control;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    logic        stall;
    logic        err;

    modport slave (
        input  if_req, if_addr, mem_read_control, mem_write_control,
               mem_addr, mem_wdata, ram_rdata, ram_ready,
        output if_rdata, if_ack, mem_rdata, mem_ack,
               ram_en, ram_we, ram_addr, ram_wdata, stall, err
    );

    modport master (
        output if_req, if_addr, mem_read_control, mem_write_control,
               mem_addr, mem_wdata, ram_rdata, ram_ready,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
               ram_en, ram_we, ram_addr, ram_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port RAM with ready-timeout and sticky err.
// Optional macro MEM_ARB_RR_EN: alternate grants when both sides contend.
//
// state   | meaning
// IDLE    | sample requests, pick a side, latch address/data/we
// GRANT_I | fetch access on RAM, waiting for ram_ready or timeout
// GRANT_D | data access on RAM, waiting for ram_ready or timeout
// RESP    | one-cycle ack to the served requester
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        err_q, err_d;
    logic        data_pend;
    logic        pick_d;
    logic        in_grant;
`ifdef MEM_ARB_RR_EN
    logic        last_d_q, last_d_d;
`endif

    assign data_pend = bus.mem_read_control | bus.mem_write_control;
    assign in_grant  = (state_q == GRANT_I) || (state_q == GRANT_D);

`ifdef MEM_ARB_RR_EN
    // last_d_q = 1 means data won the previous grant
    assign pick_d = data_pend & (~bus.if_req | ~last_d_q);
`else
    assign pick_d = data_pend;
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        err_d       = err_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_pend || bus.if_req) begin
                    wait_d  = 8'd0;
                    addr_d  = pick_d ? bus.mem_addr : bus.if_addr;
                    wdata_d = pick_d ? bus.mem_wdata : 32'd0;
                    we_d    = pick_d & bus.mem_write_control;
                    state_d = pick_d ? GRANT_D : GRANT_I;
`ifdef MEM_ARB_RR_EN
                    last_d_d = pick_d;
`endif
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.ram_ready) begin
                    state_d = RESP;
                    if (state_q == GRANT_I) begin
                        if_rdata_d = bus.ram_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!we_q)
                            mem_rdata_d = bus.ram_rdata;
                        mem_ack_d = 1'b1;
                    end
                end else if (wait_q + 8'd1 == MAX_W8) begin
                    // timeout: complete the access with zero data and flag it
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (state_q == GRANT_I) begin
                        if_rdata_d = 32'd0;
                        if_ack_d   = 1'b1;
                    end else begin
                        mem_rdata_d = 32'd0;
                        mem_ack_d   = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign bus.ram_en    = in_grant;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.err       = err_q;
    assign bus.stall     = (bus.if_req & ~if_ack_q) | (data_pend & ~mem_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level arbitration model.
module tb_mem_arbiter;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // requester state (held until acked)
    logic        f_pend = 1'b0, d_pend = 1'b0, d_we = 1'b0, d_rd = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    // model of visible results
    logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;
    logic        exp_err = 1'b0;
    logic        last_data = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.if_req            = f_pend;
        bus.if_addr           = f_addr;
        bus.mem_read_control  = d_pend & d_rd;
        bus.mem_write_control = d_pend & d_we;
        bus.mem_addr          = d_addr;
        bus.mem_wdata         = d_wdata;
    endtask

    task automatic new_fetch(input logic [31:0] a);
        f_pend = 1'b1; f_addr = a;
        drive_reqs();
    endtask

    task automatic new_data(input logic we, input logic rd, input logic [31:0] a,
                            input logic [31:0] wd);
        d_pend = 1'b1; d_we = we; d_rd = rd; d_addr = a; d_wdata = wd;
        drive_reqs();
    endtask

    task automatic model_reset();
        exp_if_rdata = '0; exp_mem_rdata = '0; exp_err = 1'b0; last_data = 1'b0;
    endtask

    // Called at a negedge with the arbiter idle and requests stable; serves one
    // access with RAM ready after 'lat' wait cycles, returns at the following idle negedge.
    task automatic serve(input int lat, input logic [31:0] rdata);
        logic side_d;
        logic tmo;
        int   ncyc;
`ifdef MEM_ARB_RR_EN
        side_d = d_pend && (!f_pend || !last_data);
`else
        side_d = d_pend;
`endif
        last_data = side_d;
        tmo  = (lat >= MW);
        ncyc = tmo ? MW : lat + 1;
        bus.ram_ready = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("ram_en", {31'd0, bus.ram_en}, 32'd1);
            chk("ram_addr", bus.ram_addr, side_d ? d_addr : f_addr);
            chk("ram_we", {31'd0, bus.ram_we}, {31'd0, side_d & d_we});
            if (side_d && d_we) chk("ram_wdata", bus.ram_wdata, d_wdata);
            chk("stall_grant", {31'd0, bus.stall}, 32'd1);
            chk("ack_in_grant", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
            bus.ram_ready = (c == lat);
            bus.ram_rdata = (c == lat) ? rdata : $urandom;
        end
        @(negedge clk);
        bus.ram_ready = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
        if (tmo) exp_err = 1'b1;
        if (side_d) begin
            if (tmo) exp_mem_rdata = 32'd0;
            else if (!d_we) exp_mem_rdata = rdata;
        end else begin
            exp_if_rdata = tmo ? 32'd0 : rdata;
        end
        chk("ram_en_resp", {31'd0, bus.ram_en}, 32'd0);
        chk("if_ack", {31'd0, bus.if_ack}, {31'd0, ~side_d});
        chk("mem_ack", {31'd0, bus.mem_ack}, {31'd0, side_d});
        chk("if_rdata", bus.if_rdata, exp_if_rdata);
        chk("mem_rdata", bus.mem_rdata, exp_mem_rdata);
        chk("err", {31'd0, bus.err}, {31'd0, exp_err});
        chk("stall_resp", {31'd0, bus.stall}, {31'd0, side_d ? f_pend : d_pend});
        if (side_d) d_pend = 1'b0; else f_pend = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("ram_en_idle", {31'd0, bus.ram_en}, 32'd0);
        chk("ack_idle", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"}, {31'd0, bus.ram_en}, 32'd0);
        chk({tag, "_ram_we"}, {31'd0, bus.ram_we}, 32'd0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
        chk({tag, "_acks"}, {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    endtask

    initial begin
        bus.ram_ready = 1'b0;
        bus.ram_rdata = '0;
        drive_reqs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // directed load, store with 3 waits, fetch timeout at MAX_WAIT
        new_data(1'b0, 1'b1, 32'h100, 32'h0);
        serve(0, 32'hDEADBEEF);
        new_data(1'b1, 1'b0, 32'h40, 32'h12345678);
        serve(3, 32'hCAFEF00D);
        new_fetch(32'h200);
        serve(MW, 32'h55555555);

        // contention: data re-requests after each ack while fetch stays pending
        new_fetch(32'h300);
        for (int k = 0; k < 3; k++) begin
            if (!d_pend) new_data(1'b0, 1'b1, 32'h400 + 32'(k * 4), 32'h0);
            serve(0, 32'hA0000000 + 32'(k));
        end
        while (f_pend || d_pend) serve(1, $urandom);

        // randomized traffic
        for (int r = 0; r < 250; r++) begin
            if (!f_pend && $urandom_range(0, 2) != 0) new_fetch($urandom);
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                logic we;
                we = 1'($urandom_range(0, 1));
                new_data(we, we ? 1'($urandom_range(0, 1)) : 1'b1, $urandom, $urandom);
            end
            if (f_pend || d_pend) begin
                serve($urandom_range(0, MW + 1), $urandom);
            end else begin
                bus.ram_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("ram_en_quiet", {31'd0, bus.ram_en}, 32'd0);
            end
        end

        // reset in the second data grant cycle: no ack, everything cleared
        while (f_pend || d_pend) serve(0, $urandom);
        new_data(1'b0, 1'b1, 32'h800, 32'h0);
        bus.ram_ready = 1'b0;
        @(negedge clk);
        chk("rg_ram_en1", {31'd0, bus.ram_en}, 32'd1);
        @(negedge clk);
        chk("rg_ram_en2", {31'd0, bus.ram_en}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        model_reset();
        rst = 1'b1;
        serve(0, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
